uart_tx_frame: RTL and testbench

// - UART transmit-side framer/serializer; TX counterpart of the oversampled UART RX path.
// - Accepts one byte per handshake and shifts out start bit, 8 data bits (LSB first), optional parity bit and stop bit.
// - Each bit is held for PRESCALE clk cycles, sharing the RX oversampling clock and prescale setting.
// - Sits between the system-side TX FIFO/controller and the serial line pin.

---
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_tx_frame.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Handshake/data bundle between the system-side TX controller (master)
// and the uart_tx_frame serializer (slave).
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_WIDTH  = 6
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [PRE_WIDTH-1:0]  prescale;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer/serializer.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// stop bit(s). Each bit is held for P clk cycles, P = latched prescale
// (prescale 0 or 1 both mean one cycle per bit).
// Optional feature macro: UART_TX_TWO_STOP_EN -- when defined, two stop
// bits (2*P cycles of stop) are sent instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_WIDTH  = 6
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int         IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRE_WIDTH-1:0]  last_q;     // latched P-1, compare value of the edge counter
  logic [PRE_WIDTH-1:0]  edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  tx_q;
  logic                  busy_q;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q;    // second stop bit in progress
`endif

  logic       edge_wrap;
  logic [3:0] bit_nxt;
  logic       par_bit;

  assign edge_wrap = (edge_cnt == last_q);
  assign bit_nxt   = bit_cnt + 4'd1;
  // Parity comes from the latched byte, so mid-frame p_data changes cannot leak in.
  assign par_bit   = (^data_q) ^ par_typ_q;

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

  // Frame FSM: accepts a request in IDLE, then walks the bit slots with registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      last_q    <= '0;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      if (bus.data_valid) begin
        data_q    <= bus.p_data;
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
        last_q    <= (bus.prescale > PRE_WIDTH'(1)) ? bus.prescale - PRE_WIDTH'(1) : '0;
        state     <= S_START;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
      end
    end else if (!edge_wrap) begin
      edge_cnt <= edge_cnt + PRE_WIDTH'(1);
    end else begin
      edge_cnt <= '0;
      case (state)
        S_START: begin
          state   <= S_DATA;
          bit_cnt <= '0;
          tx_q    <= data_q[0];
        end
        S_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              state <= S_PARITY;
              tx_q  <= par_bit;
            end else begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_nxt;
            tx_q    <= data_q[bit_nxt[IDX_W-1:0]];
          end
        end
        S_PARITY: begin
          state <= S_STOP;
          tx_q  <= 1'b1;
        end
        S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop2_q) begin
            stop2_q <= 1'b1;
          end else begin
            stop2_q <= 1'b0;
            state   <= S_IDLE;
            busy_q  <= 1'b0;
          end
`else
          state  <= S_IDLE;
          busy_q <= 1'b0;
`endif
        end
        default: begin
          state  <= S_IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame.
// Honours UART_TX_TWO_STOP_EN so the same bench covers both builds.
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8), .PRE_WIDTH(6)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8), .PRE_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected busy length of a frame.
  function automatic int exp_len(input logic pe, input int p);
    return (9 + int'(pe) + NSTOP) * p;
  endfunction

  // Reference serial waveform: slot 0 start, 1..8 data LSB first, 9 parity if enabled, then stop.
  function automatic int wave_errs(input logic [511:0] w, input int len, input logic [7:0] d,
                                   input logic pe, input logic pt, input int p);
    int e;
    e = 0;
    for (int c = 0; c < len; c++) begin
      int   b;
      logic x;
      b = c / p;
      if (b == 0)             x = 1'b0;
      else if (b <= 8)        x = d[b-1];
      else if (pe && b == 9)  x = (^d) ^ pt;
      else                    x = 1'b1;
      if (w[c] !== x) e++;
    end
    return e;
  endfunction

  // One-cycle request; returns sampled just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.prescale   = ps;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
  endtask

  // Records tx_out for every busy cycle. Optionally raises a 0x3C request
  // (with other settings changed) at slot inj_at, held until frame end if inj_hold.
  task automatic capture(input int inj_at, input bit inj_hold,
                         output int len, output logic [511:0] w);
    len = 0;
    w   = '1;
    while (bus.busy === 1'b1 && len < LIMIT) begin
      w[len] = bus.tx_out;
      if (len == inj_at) begin
        bus.data_valid = 1'b1;
        bus.p_data     = 8'h3C;
        bus.par_en     = 1'b1;
        bus.par_typ    = 1'b1;
        bus.prescale   = 6'd4;
      end
      step();
      len++;
      if (!inj_hold && len == inj_at + 1) bus.data_valid = 1'b0;
    end
  endtask

  initial begin
    int           len;
    int           cnt;
    logic [511:0] w;
    logic [9:0]   ctr;

    rst            = 1'b1;
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.prescale   = 6'd8;
    repeat (3) step();
    check("reset_tx", bus.tx_out, 1);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;
    step();
    check("idle_tx", bus.tx_out, 1);

    // 0xA5, P=8, no parity
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    capture(-1, 1'b0, len, w);
    check("a5_len", len, exp_len(1'b0, 8));
    check("a5_wave", wave_errs(w, len, 8'hA5, 1'b0, 1'b0, 8), 0);
    for (int b = 0; b < 10; b++) ctr[b] = w[b*8+4];
    check("a5_bits", {22'd0, ctr}, 32'h34A);

    // Even parity then odd parity
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    capture(-1, 1'b0, len, w);
    check("even_len", len, exp_len(1'b1, 8));
    check("even_wave", wave_errs(w, len, 8'hA5, 1'b1, 1'b0, 8), 0);
    check("even_par", w[9*8+4], 0);
    send(8'hA5, 1'b1, 1'b1, 6'd8);
    capture(-1, 1'b0, len, w);
    check("odd_len", len, exp_len(1'b1, 8));
    check("odd_wave", wave_errs(w, len, 8'hA5, 1'b1, 1'b1, 8), 0);
    check("odd_par", w[9*8+4], 1);

    // Request pulse mid-frame is ignored, no second frame follows
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    capture(20, 1'b0, len, w);
    check("ign_len", len, exp_len(1'b0, 8));
    check("ign_wave", wave_errs(w, len, 8'hA5, 1'b0, 1'b0, 8), 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.busy !== 1'b0) cnt++;
      step();
    end
    check("ign_no_second", cnt, 0);

    // Request held from mid-frame is accepted in the single IDLE cycle after it
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    capture(20, 1'b1, len, w);
    check("hold_len1", len, exp_len(1'b0, 8));
    check("hold_wave1", wave_errs(w, len, 8'hA5, 1'b0, 1'b0, 8), 0);
    check("hold_idle_gap", bus.busy, 0);
    step();
    bus.data_valid = 1'b0;
    check("hold_accept", {bus.busy, bus.tx_out}, 2'b10);
    capture(-1, 1'b0, len, w);
    check("hold_len2", len, exp_len(1'b1, 4));
    check("hold_wave2", wave_errs(w, len, 8'h3C, 1'b1, 1'b1, 4), 0);

    // Reset during data bit 3 abandons the frame
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    repeat (35) step();
    check("mid_bit3", bus.tx_out, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_tx", bus.tx_out, 1);
    check("mid_rst_busy", bus.busy, 0);
    step();
    send(8'hFF, 1'b0, 1'b0, 6'd8);
    capture(-1, 1'b0, len, w);
    check("ff_len", len, exp_len(1'b0, 8));
    check("ff_wave", wave_errs(w, len, 8'hFF, 1'b0, 1'b0, 8), 0);

    // Reset wins over a simultaneous request
    rst            = 1'b1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'h55;
    step();
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    check("prio_busy", bus.busy, 0);
    check("prio_tx", bus.tx_out, 1);
    step();
    check("prio_no_frame", bus.busy, 0);

    // prescale 0 and 1 both give one-cycle bits
    send(8'h01, 1'b0, 1'b0, 6'd0);
    capture(-1, 1'b0, len, w);
    check("p0_len", len, exp_len(1'b0, 1));
    check("p0_wave", wave_errs(w, len, 8'h01, 1'b0, 1'b0, 1), 0);
    send(8'h01, 1'b0, 1'b0, 6'd1);
    capture(-1, 1'b0, len, w);
    check("p1_len", len, exp_len(1'b0, 1));
    check("p1_wave", wave_errs(w, len, 8'h01, 1'b0, 1'b0, 1), 0);

    // P=16 with parity: 192 cycles with two stop bits, 176 with one
    send(8'h96, 1'b1, 1'b0, 6'd16);
    capture(-1, 1'b0, len, w);
    check("p16_len", len, exp_len(1'b1, 16));
    check("p16_wave", wave_errs(w, len, 8'h96, 1'b1, 1'b0, 16), 0);
    cnt = 0;
    for (int c = len - NSTOP * 16; c < len; c++) if (c >= 0 && w[c] === 1'b1) cnt++;
    check("p16_stop_tail", cnt, NSTOP * 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
